// File: rtl/io_rx_fifo_port_pkg.sv
// rtl/io_rx_fifo_port_pkg.sv - register offsets, bit positions and decode types for io_rx_fifo_port
package io_rx_fifo_port_pkg;

    // Register offsets relative to BASE_ADDR
    localparam int REG_DATA   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_CTRL   = 2;

    // STATUS bit positions
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_COUNT_LSB = 3;
    localparam int STAT_COUNT_W   = 5;

    // CTRL bit positions
    localparam int CTRL_IEN     = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_THR_LSB = 4;
    localparam int CTRL_THR_MSB = 7;
    localparam int CTRL_THR_W   = CTRL_THR_MSB - CTRL_THR_LSB + 1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DATA,
        SEL_STATUS,
        SEL_CTRL
    } reg_sel_e;

    function automatic logic [7:0] pack_status(
        input logic                    empty,
        input logic                    full,
        input logic [STAT_COUNT_W-1:0] count
    );
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_EMPTY]     = empty;
        s[STAT_FULL]      = full;
        s[7:STAT_COUNT_LSB] = count;
        return s;
    endfunction

    function automatic logic [7:0] pack_ctrl(
        input logic                  ien,
        input logic [CTRL_THR_W-1:0] thr
    );
        logic [7:0] c;
        c                              = 8'h00;
        c[CTRL_IEN]                    = ien;
        c[CTRL_THR_MSB:CTRL_THR_LSB]   = thr;
        return c;
    endfunction

endpackage

// File: rtl/io_rx_fifo_port_if.sv
// rtl/io_rx_fifo_port_if.sv - IO register bus plus inbound byte stream for io_rx_fifo_port
// Ports (signals):
//   addr/wr_dat/wr/rd : IO register access from the core
//   rd_dat            : read data slice, zero when this block is not read
//   in_data/in_valid  : inbound byte stream
//   in_ready          : FIFO can accept in_data this cycle
interface io_rx_fifo_port_if #(
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wr_dat;
    logic                  wr;
    logic                  rd;
    logic [7:0]            rd_dat;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;

    // Core and stream producer side
    modport master (
        output addr, wr_dat, wr, rd, in_data, in_valid,
        input  rd_dat, in_ready
    );

    // Peripheral side
    modport slave (
        input  addr, wr_dat, wr, rd, in_data, in_valid,
        output rd_dat, in_ready
    );
endinterface

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - single-clock FIFO with synchronous flush and combinational head
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : clears pointers and count on the edge, overrides push/pop
//   push, din         : write request and data (ignored when full)
//   pop               : read request (ignored when empty)
//   dout              : head entry, valid whenever !empty
//   count, count_next : current fill level and the level after this edge
//   full, empty       : fill flags
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers are exactly AW bits so they wrap at DEPTH with no extra logic
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Storage has no reset; stale entries are never visible because DATA is gated by empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end
endmodule

// File: rtl/io_rx_fifo_port.sv
// rtl/io_rx_fifo_port.sv - IO-space receive FIFO with DATA/STATUS/CTRL registers and threshold irq
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : IO register access and inbound byte stream (slave side)
//   irq      : registered level interrupt, IEN && count > THR
module io_rx_fifo_port
    import io_rx_fifo_port_pkg::*;
#(
    parameter int                        BUS_ADDR_WIDTH = 6,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = 6'h20,
    parameter int                        DEPTH          = 16
) (
    input  logic                clk,
    input  logic                rst,
    io_rx_fifo_port_if.slave    bus,
    output logic                irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_DATA   = BASE_ADDR + BUS_ADDR_WIDTH'(REG_DATA);
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_STATUS = BASE_ADDR + BUS_ADDR_WIDTH'(REG_STATUS);
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_CTRL   = BASE_ADDR + BUS_ADDR_WIDTH'(REG_CTRL);

    reg_sel_e              sel;
    logic                  ctrl_wr;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic [7:0]            head;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  full;
    logic                  empty;
    logic                  ien;
    logic [CTRL_THR_W-1:0] thr;
    logic                  ien_next;
    logic [CTRL_THR_W-1:0] thr_next;

    // Full-width address compare so aliases elsewhere in IO space never hit
    always_comb begin
        sel = SEL_NONE;
        if (bus.addr == ADDR_DATA) begin
            sel = SEL_DATA;
        end else if (bus.addr == ADDR_STATUS) begin
            sel = SEL_STATUS;
        end else if (bus.addr == ADDR_CTRL) begin
            sel = SEL_CTRL;
        end
    end

    assign ctrl_wr = bus.wr && (sel == SEL_CTRL);
    assign flush   = ctrl_wr && bus.wr_dat[CTRL_FLUSH];

    // Deasserting ready during a flush write makes flush win over a coincident push
    assign bus.in_ready = !full && !flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.rd && (sel == SEL_DATA);

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .pop        (pop),
        .din        (bus.in_data),
        .dout       (head),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        ien_next = ien;
        thr_next = thr;
        if (ctrl_wr) begin
            ien_next = bus.wr_dat[CTRL_IEN];
            thr_next = bus.wr_dat[CTRL_THR_MSB:CTRL_THR_LSB];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ien <= 1'b0;
            thr <= '0;
        end else begin
            ien <= ien_next;
            thr <= thr_next;
        end
    end

    // Uses post-edge count and CTRL so irq tracks the state established on the same edge;
    // THR >= DEPTH can never be exceeded since count tops out at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= ien_next &&
                   (STAT_COUNT_W'(count_next) > STAT_COUNT_W'(thr_next));
        end
    end

    // rd_dat feeds an OR-combiner, so it must be zero unless this block is being read
    always_comb begin
        bus.rd_dat = 8'h00;
        if (bus.rd) begin
            case (sel)
                SEL_DATA:   bus.rd_dat = empty ? 8'h00 : head;
                SEL_STATUS: bus.rd_dat = pack_status(empty, full, STAT_COUNT_W'(count));
                SEL_CTRL:   bus.rd_dat = pack_ctrl(ien, thr);
                default:    bus.rd_dat = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_io_rx_fifo_port.sv
// tb/tb_io_rx_fifo_port.sv - directed self-checking bench for io_rx_fifo_port
module tb_io_rx_fifo_port;
    localparam logic [5:0] A_DATA = 6'h20;
    localparam logic [5:0] A_STAT = 6'h21;
    localparam logic [5:0] A_CTRL = 6'h22;

    logic clk = 1'b0;
    logic rst;
    logic irq;

    io_rx_fifo_port_if #(.ADDR_WIDTH(6)) bus ();

    io_rx_fifo_port #(
        .BUS_ADDR_WIDTH (6),
        .BASE_ADDR      (6'h20),
        .DEPTH          (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd       = 1'b0;
        bus.wr       = 1'b0;
        bus.in_valid = 1'b0;
        bus.addr     = 6'h00;
        bus.wr_dat   = 8'h00;
        bus.in_data  = 8'h00;
    endtask

    task automatic rd_reg(input logic [5:0] a, output logic [7:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1;
        d = bus.rd_dat;
        step();
        bus.rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [5:0] a, input logic [7:0] d);
        bus.addr   = a;
        bus.wr_dat = d;
        bus.wr     = 1'b1;
        step();
        bus.wr = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] b);
        int n;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        #1;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        total++;
        assert (bus.in_ready === 1'b1) else begin
            bad++;
            $error("FAIL push_timeout observed=%b expected=1", bus.in_ready);
        end
        if (bus.in_ready === 1'b1) sb.push_back(b);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] exp;
        logic [7:0] d;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        rd_reg(A_DATA, d);
        chk(tag, d, exp);
    endtask

    logic [7:0] d;
    logic [7:0] last;

    initial begin
        idle();
        // Reset with in_valid held high: nothing may be captured
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        step();
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_rd_dat", bus.rd_dat, 8'h00);
        chk("rst_in_ready", {7'b0, bus.in_ready}, 8'h01);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        rd_reg(A_STAT, d);
        chk("rst_status", d, 8'h01);

        // Ordered drain across pointer wrap
        push_b(8'h11);
        push_b(8'h22);
        push_b(8'h33);
        for (int i = 0; i < 3; i++) pop_chk("drain_a");
        for (int i = 0; i < 16; i++) push_b(8'h40 + 8'(i));
        rd_reg(A_STAT, d);
        chk("full_status", d, 8'h82);
        #1;
        chk("full_in_ready", {7'b0, bus.in_ready}, 8'h00);
        for (int i = 0; i < 16; i++) pop_chk("drain_wrap");
        rd_reg(A_STAT, d);
        chk("empty_status", d, 8'h01);
        pop_chk("empty_data");

        // Full-boundary concurrent push and pop
        for (int i = 0; i < 16; i++) push_b(8'h60 + 8'(i));
        bus.addr     = A_DATA;
        bus.rd       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        #1;
        chk("conc_in_ready", {7'b0, bus.in_ready}, 8'h00);
        chk("conc_data", bus.rd_dat, sb.pop_front());
        step();
        bus.rd = 1'b0;
        #1;
        chk("conc_ready_back", {7'b0, bus.in_ready}, 8'h01);
        step();
        sb.push_back(8'hAA);
        bus.in_valid = 1'b0;
        rd_reg(A_STAT, d);
        chk("conc_status", d, 8'h82);
        for (int i = 0; i < 15; i++) pop_chk("conc_drain");
        rd_reg(A_DATA, last);
        chk("conc_last", last, 8'hAA);
        void'(sb.pop_front());

        // Threshold interrupt
        wr_reg(A_CTRL, 8'h31);
        rd_reg(A_CTRL, d);
        chk("ctrl_rb", d, 8'h31);
        push_b(8'h01);
        push_b(8'h02);
        push_b(8'h03);
        chk("irq_at3", {7'b0, irq}, 8'h00);
        push_b(8'h04);
        chk("irq_at4", {7'b0, irq}, 8'h01);
        pop_chk("irq_pop");
        chk("irq_fall", {7'b0, irq}, 8'h00);
        push_b(8'h05);
        chk("irq_rise2", {7'b0, irq}, 8'h01);
        wr_reg(A_CTRL, 8'h30);
        chk("irq_ien_off", {7'b0, irq}, 8'h00);

        // Flush beats a coincident push
        push_b(8'h06);
        rd_reg(A_STAT, d);
        chk("pre_flush_status", d, 8'h28);
        bus.addr     = A_CTRL;
        bus.wr_dat   = 8'h02;
        bus.wr       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        #1;
        chk("flush_in_ready", {7'b0, bus.in_ready}, 8'h00);
        step();
        bus.wr       = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        rd_reg(A_STAT, d);
        chk("flush_status", d, 8'h01);
        rd_reg(A_CTRL, d);
        chk("flush_ctrl", d, 8'h00);

        // Bus isolation
        push_b(8'h71);
        push_b(8'h72);
        rd_reg(6'h1F, d);
        chk("iso_below", d, 8'h00);
        rd_reg(6'h23, d);
        chk("iso_above", d, 8'h00);
        wr_reg(A_DATA, 8'hFF);
        wr_reg(A_STAT, 8'hFF);
        rd_reg(A_STAT, d);
        chk("iso_status", d, 8'h10);
        rd_reg(A_CTRL, d);
        chk("iso_ctrl", d, 8'h00);
        pop_chk("iso_drain");
        pop_chk("iso_drain");
        pop_chk("iso_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
